// File: rtl/sum_tree_pipe.sv
// Pipelined unsigned reduction adder: registered binary tree with optional accumulate window.
// Build option: SUMTREE_SIGNED_EN selects two's-complement operands and signed overflow.

module sum_tree_node #(
    parameter int W   = 8,
    parameter bit SGN = 1'b0
) (
    input  logic         Clk,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   s
);
    // Data registers carry no reset; only the valid bits define pipeline contents.
    always_ff @(posedge Clk)
        if (en) s <= {SGN & a[W-1], a} + {SGN & b[W-1], b};
endmodule

module sum_tree_pipe #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_IN    = 16,
    parameter int OUTWIDTH  = 32,
    parameter int CNTWIDTH  = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_IN*DATAWIDTH-1:0] In,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic                        Mode,
    input  logic [CNTWIDTH-1:0]         AccLen,
    output logic [OUTWIDTH-1:0]         Final,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic                        Ovf
);
    localparam int L   = $clog2(NUM_IN);
    localparam int RW  = DATAWIDTH + L;
    localparam int MSB = OUTWIDTH - 1;
`ifdef SUMTREE_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    generate
        if (NUM_IN < 2 || (1 << L) != NUM_IN) begin : g_bad_num_in
            $error("sum_tree_pipe: NUM_IN must be a power of 2 and at least 2");
        end
        if (OUTWIDTH < RW) begin : g_bad_outwidth
            $error("sum_tree_pipe: OUTWIDTH must be at least DATAWIDTH+log2(NUM_IN)");
        end
    endgenerate

    logic                    advance;
    logic [L:0]              vld_pipe;
    logic [L:0]              mode_pipe;
    logic [L:0][CNTWIDTH-1:0] len_pipe;

    // A single global stall: nothing moves while a result waits on the output.
    assign advance = !OutValid || OutReady;
    assign InReady = advance;

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst)         vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[L-1:0], InValid};

    // Each sample carries its own Mode/AccLen so the window sees accept-time settings.
    always_ff @(posedge Clk)
        if (advance) begin
            mode_pipe <= {mode_pipe[L-1:0], Mode};
            len_pipe  <= {len_pipe[L-1:0], AccLen};
        end

    genvar j, k;
    generate
        for (j = 0; j <= L; j++) begin : lvl
            logic [DATAWIDTH+j-1:0] s [NUM_IN>>j];
            if (j == 0) begin : g_in
                for (k = 0; k < NUM_IN; k++) begin : elem
                    always_ff @(posedge Clk)
                        if (advance) s[k] <= In[k*DATAWIDTH +: DATAWIDTH];
                end
            end else begin : g_add
                for (k = 0; k < (NUM_IN >> j); k++) begin : node
                    sum_tree_node #(.W(DATAWIDTH+j-1), .SGN(SGN)) u_node (
                        .Clk (Clk),
                        .en  (advance),
                        .a   (lvl[j-1].s[2*k]),
                        .b   (lvl[j-1].s[2*k+1]),
                        .s   (s[k])
                    );
                end
            end
        end
    endgenerate

    logic [OUTWIDTH-1:0] res, acc, sum;
    logic [OUTWIDTH:0]   add_full;
    logic [CNTWIDTH-1:0] cnt, lat_len, cur_len, len1;
    logic                lat_mode, cur_mode, sticky, wrap, last;

    generate
        if (SGN) begin : g_sext
            assign res = OUTWIDTH'($signed(lvl[L].s[0]));
        end else begin : g_zext
            assign res = OUTWIDTH'(lvl[L].s[0]);
        end
    endgenerate

    // Window settings come from the sample itself when it opens a window.
    always_comb begin
        cur_mode = (cnt == '0) ? mode_pipe[L] : lat_mode;
        cur_len  = (cnt == '0) ? len_pipe[L]  : lat_len;
        len1     = (cur_len == '0) ? CNTWIDTH'(1) : cur_len;
        last     = (cnt == len1 - CNTWIDTH'(1));
        add_full = {1'b0, acc} + {1'b0, res};
        sum      = add_full[OUTWIDTH-1:0];
        wrap     = SGN ? ((acc[MSB] == res[MSB]) && (sum[MSB] != acc[MSB]))
                       : add_full[OUTWIDTH];
    end

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            Final    <= '0;
            OutValid <= 1'b0;
            Ovf      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            lat_mode <= 1'b0;
            lat_len  <= '0;
        end else if (advance) begin
            OutValid <= 1'b0;
            if (vld_pipe[L]) begin
                if (!cur_mode) begin
                    Final    <= res;
                    Ovf      <= 1'b0;
                    OutValid <= 1'b1;
                end else if (last) begin
                    Final    <= sum;
                    Ovf      <= sticky | wrap;
                    OutValid <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc      <= sum;
                    cnt      <= cnt + CNTWIDTH'(1);
                    sticky   <= sticky | wrap;
                    lat_mode <= cur_mode;
                    lat_len  <= cur_len;
                end
            end
        end
endmodule

// File: tb/tb_sum_tree_pipe.sv
// Bench for sum_tree_pipe: directed scenarios plus randomized traffic against a window-level model.
module tb_sum_tree_pipe;
    localparam int DW = 8;
    localparam int N  = 16;
    localparam int CW = 8;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [N*DW-1:0]   In;
    logic              InValid, Mode, OutReady;
    logic [CW-1:0]     AccLen;
    logic              InReady, OutValid, Ovf;
    logic [31:0]       Final;
    logic              InReady12, OutValid12, Ovf12;
    logic [11:0]       Final12;

    int total = 0;
    int bad   = 0;

    typedef struct { longint f; bit o; } res_t;
    res_t   exp0[$], exp1[$], obs0[$], obs1[$];
    res_t   mr;
    int     wcnt[2];
    longint wacc[2];
    bit     wmode[2];
    int     wlen[2];

    always #5 Clk = ~Clk;

    sum_tree_pipe #(.DATAWIDTH(DW), .NUM_IN(N), .OUTWIDTH(32), .CNTWIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(InReady),
        .Mode(Mode), .AccLen(AccLen), .Final(Final), .OutValid(OutValid),
        .OutReady(OutReady), .Ovf(Ovf)
    );

    sum_tree_pipe #(.DATAWIDTH(DW), .NUM_IN(N), .OUTWIDTH(12), .CNTWIDTH(CW)) dut12 (
        .Clk(Clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(InReady12),
        .Mode(Mode), .AccLen(AccLen), .Final(Final12), .OutValid(OutValid12),
        .OutReady(OutReady), .Ovf(Ovf12)
    );

    function automatic longint esum(input logic [N*DW-1:0] v);
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(v[k*DW +: DW]);
        return s;
    endfunction

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] e);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = e;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] kpat();
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Window model: settings fixed by the first sample of a window, wide sum reduced at close.
    task automatic model_acc(input int i, input longint s, input bit md, input int len, input int ow);
        res_t   r;
        bit     emit = 0;
        longint m = longint'(1) << ow;
        if (wcnt[i] == 0) begin
            wmode[i] = md;
            wlen[i]  = (len == 0) ? 1 : len;
        end
        if (!wmode[i]) begin
            r.f = s % m; r.o = 0; emit = 1;
        end else begin
            wacc[i] += s;
            wcnt[i]++;
            if (wcnt[i] == wlen[i]) begin
                r.f = wacc[i] % m; r.o = (wacc[i] >= m); emit = 1;
                wacc[i] = 0; wcnt[i] = 0;
            end
        end
        if (emit) begin
            if (i == 0) exp0.push_back(r);
            else        exp1.push_back(r);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
            for (int i = 0; i < 2; i++) begin wcnt[i] = 0; wacc[i] = 0; end
        end else begin
            if (InValid && InReady)   model_acc(0, esum(In), Mode, int'(AccLen), 32);
            if (InValid && InReady12) model_acc(1, esum(In), Mode, int'(AccLen), 12);
            if (OutValid && OutReady) begin
                mr.f = longint'(Final); mr.o = Ovf; obs0.push_back(mr);
            end
            if (OutValid12 && OutReady) begin
                mr.f = longint'(Final12); mr.o = Ovf12; obs1.push_back(mr);
            end
        end
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0; InValid = 1'b0; OutReady = 1'b1; Mode = 1'b0; AccLen = '0; In = '0;
        repeat (2) tick();
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Rst = 1'b0; InValid = 1'b0; OutReady = 1'b0; Mode = 1'b0; AccLen = '0; In = '0;
        tick();
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
        total++; if (Final !== 32'd0)   begin bad++; $display("FAIL reset_final got=%0d exp=0", Final); end
        total++; if (Ovf !== 1'b0)      begin bad++; $display("FAIL reset_ovf got=%b exp=0", Ovf); end
        total++; if (InReady !== 1'b1)  begin bad++; $display("FAIL reset_inready got=%b exp=1", InReady); end
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int first = 0, npulse = 0;
        logic [31:0] fv = '0;
        logic fo = 1'b0;
        do_reset();
        In = fill(8'hFF); InValid = 1'b1;
        tick();
        InValid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (OutValid) begin
                npulse++;
                if (first == 0) begin first = n; fv = Final; fo = Ovf; end
            end
        end
        total++; if (first != 5)      begin bad++; $display("FAIL lat_edges got=%0d exp=5", first); end
        total++; if (npulse != 1)     begin bad++; $display("FAIL lat_pulses got=%0d exp=1", npulse); end
        total++; if (fv !== 32'd4080) begin bad++; $display("FAIL lat_final got=%0d exp=4080", fv); end
        total++; if (fo !== 1'b0)     begin bad++; $display("FAIL lat_ovf got=%b exp=0", fo); end
    endtask

    task automatic test_back_to_back();
        int          vc[$];
        logic [31:0] vf[$];
        do_reset();
        In = kpat(); InValid = 1'b1;
        tick();
        In = fill(8'd1);
        tick();
        InValid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (OutValid) begin vc.push_back(n); vf.push_back(Final); end
        end
        total++;
        if (vc.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", vc.size());
        end else begin
            total++; if (vc[1] != vc[0] + 1) begin bad++; $display("FAIL b2b_consecutive got=%0d,%0d", vc[0], vc[1]); end
            total++; if (vf[0] !== 32'd120)  begin bad++; $display("FAIL b2b_first got=%0d exp=120", vf[0]); end
            total++; if (vf[1] !== 32'd16)   begin bad++; $display("FAIL b2b_second got=%0d exp=16", vf[1]); end
        end
    endtask

    task automatic test_stall();
        logic [N*DW-1:0] smp[6];
        longint          want[6];
        int              sent = 0;
        do_reset();
        smp[0] = kpat();
        for (int i = 1; i < 6; i++) smp[i] = rnd();
        for (int i = 0; i < 6; i++) want[i] = esum(smp[i]);
        for (int c = 0; c < 24; c++) begin
            OutReady = !(c >= 5 && c <= 8);
            if (sent < 6) begin In = smp[sent]; InValid = 1'b1; end
            else InValid = 1'b0;
            @(negedge Clk);
            if (InValid && InReady) sent++;
            if (c >= 6 && c <= 8) begin
                total++; if (InReady !== 1'b0)  begin bad++; $display("FAIL stall_inready c=%0d got=%b exp=0", c, InReady); end
                total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL stall_outvalid c=%0d got=%b exp=1", c, OutValid); end
                total++; if (Final !== 32'd120) begin bad++; $display("FAIL stall_hold c=%0d got=%0d exp=120", c, Final); end
            end
            @(posedge Clk); #1;
        end
        InValid = 1'b0; OutReady = 1'b1;
        total++;
        if (obs0.size() != 6) begin
            bad++; $display("FAIL stall_count got=%0d exp=6", obs0.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (obs0[i].f !== want[i]) begin bad++; $display("FAIL stall_order i=%0d got=%0d exp=%0d", i, obs0[i].f, want[i]); end
            end
        end
    endtask

    task automatic test_accum();
        int npulse = 0;
        do_reset();
        Mode = 1'b1; AccLen = 8'd4; In = fill(8'hFF);
        for (int s = 0; s < 4; s++) begin
            InValid = 1'b1;
            tick();
            if (OutValid) npulse++;
            if (s == 0) AccLen = 8'd2;
        end
        InValid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (OutValid) npulse++;
        end
        total++; if (npulse != 1) begin bad++; $display("FAIL acc_pulses got=%0d exp=1", npulse); end
        total++;
        if (obs0.size() != 1) begin
            bad++; $display("FAIL acc_count got=%0d exp=1", obs0.size());
        end else begin
            total++; if (obs0[0].f != 16320) begin bad++; $display("FAIL acc_final got=%0d exp=16320", obs0[0].f); end
            total++; if (obs0[0].o != 1'b0)  begin bad++; $display("FAIL acc_ovf got=%b exp=0", obs0[0].o); end
        end
        total++;
        if (obs1.size() != 1 || exp1.size() != 1) begin
            bad++; $display("FAIL acc12_count got=%0d exp=%0d", obs1.size(), exp1.size());
        end else begin
            total++;
            if (obs1[0].f != exp1[0].f || obs1[0].o != exp1[0].o)
                begin bad++; $display("FAIL acc12_value got=%0d/%b exp=%0d/%b", obs1[0].f, obs1[0].o, exp1[0].f, exp1[0].o); end
        end
    endtask

    task automatic test_ovf12();
        do_reset();
        Mode = 1'b1; AccLen = 8'd2;
        for (int s = 0; s < 4; s++) begin
            In = (s < 2) ? fill(8'hFF) : fill(8'd1);
            InValid = 1'b1;
            tick();
        end
        InValid = 1'b0;
        repeat (12) tick();
        total++;
        if (obs1.size() != 2) begin
            bad++; $display("FAIL ovf12_count got=%0d exp=2", obs1.size());
        end else begin
            total++; if (obs1[0].f != 4064 || obs1[0].o != 1'b1) begin bad++; $display("FAIL ovf12_first got=%0d/%b exp=4064/1", obs1[0].f, obs1[0].o); end
            total++; if (obs1[1].f != 32 || obs1[1].o != 1'b0)   begin bad++; $display("FAIL ovf12_second got=%0d/%b exp=32/0", obs1[1].f, obs1[1].o); end
        end
        total++;
        if (obs0.size() != 2) begin
            bad++; $display("FAIL ovf32_count got=%0d exp=2", obs0.size());
        end else begin
            total++; if (obs0[0].f != 8160 || obs0[0].o != 1'b0) begin bad++; $display("FAIL ovf32_first got=%0d/%b exp=8160/0", obs0[0].f, obs0[0].o); end
        end
    endtask

    task automatic test_reset_inflight();
        logic [N*DW-1:0] v;
        do_reset();
        OutReady = 1'b0;
        for (int s = 0; s < 4; s++) begin In = rnd(); InValid = 1'b1; tick(); end
        InValid = 1'b0;
        repeat (4) tick();
        total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL rst_pre_outvalid got=%b exp=1", OutValid); end
        #2 Rst = 1'b0;
        #1;
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_async_outvalid got=%b exp=0", OutValid); end
        total++; if (InReady !== 1'b1)  begin bad++; $display("FAIL rst_async_inready got=%b exp=1", InReady); end
        tick();
        Rst = 1'b1; OutReady = 1'b1;
        repeat (10) tick();
        total++; if (obs0.size() != 0) begin bad++; $display("FAIL rst_discard got=%0d exp=0", obs0.size()); end
        v = rnd(); In = v; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        repeat (8) tick();
        total++;
        if (obs0.size() != 1) begin
            bad++; $display("FAIL rst_next_count got=%0d exp=1", obs0.size());
        end else begin
            total++; if (obs0[0].f != esum(v)) begin bad++; $display("FAIL rst_next_sum got=%0d exp=%0d", obs0[0].f, esum(v)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            In       = rnd();
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) Mode = ~Mode;
            AccLen   = CW'($urandom_range(0, 3));
            tick();
        end
        InValid = 1'b0; OutReady = 1'b1;
        repeat (20) tick();
        total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL rand_count32 got=%0d exp=%0d", obs0.size(), exp0.size()); end
        total++; if (obs1.size() != exp1.size()) begin bad++; $display("FAIL rand_count12 got=%0d exp=%0d", obs1.size(), exp1.size()); end
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
            total++;
            if (obs0[i].f != exp0[i].f || obs0[i].o != exp0[i].o)
                begin bad++; $display("FAIL rand32 i=%0d got=%0d/%b exp=%0d/%b", i, obs0[i].f, obs0[i].o, exp0[i].f, exp0[i].o); end
        end
        for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
            total++;
            if (obs1[i].f != exp1[i].f || obs1[i].o != exp1[i].o)
                begin bad++; $display("FAIL rand12 i=%0d got=%0d/%b exp=%0d/%b", i, obs1[i].f, obs1[i].o, exp1[i].f, exp1[i].o); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_accum();
        test_ovf12();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
